ofdmbbp_rx_cmd_sched: RTL and testbench
=======================================

# ofdmbbp_rx_cmd_sched

Command scheduler between the host command FIFO (`cmdq`, sample clock domain) and the OFDM RX core command port. It expands each host command into `repeat+1` core executions. Each execution waits for enough free space in the RX data FIFO (`dataq`), counts the output beats, and inserts a programmable pause between executions. A watchdog and an abort input recover from a stalled core. All logic runs on the sample clock.

## Interface
**Parameters**
- `TIMEOUT`, default 4096: RUN-state cycles without an `rx_dout_valid` beat before the watchdog fires (must be ≥2).
- `CNT_W`, default 16: width of `exec_cnt`.

**Ports**
- `clk` in 1: sample clock (the `s_clk` domain).
- `rst` in 1: reset, synchronous, active-high.
- `s_cmd_valid` in 1: `cmdq` not empty.
- `s_cmd_ready` out 1: pop `cmdq`.
- `s_cmd_data` in 32: `{pause[31:24], repeat[23:17], seed[16:10], mode[9:8], length[7:0]}`.
- `m_cmd_valid` out 1: command valid to the RX core.
- `m_cmd_ready` in 1: RX core accepts the command.
- `m_cmd_length` out 8: forwarded `length`.
- `m_cmd_mode` out 2: forwarded `mode`.
- `m_cmd_seed` out 7: per-execution seed.
- `rx_dout_valid` in 1: RX core output beat, also written to `dataq`.
- `dataq_free` in 11: free words in `dataq`, range 0..1024.
- `abort` in 1: return to IDLE and drop the current command.
- `busy` out 1: state ≠ IDLE.
- `seq_state` out 3: current state encoding.
- `done` out 1: one-cycle pulse when an execution completes.
- `err_timeout` out 1: one-cycle pulse when the watchdog fires.
- `exec_cnt` out CNT_W: completed executions, wraps at 2^CNT_W.
- `timeout_cnt` out 8: watchdog events, saturates at 255.

## Operation
- **States:** IDLE=0, WAIT_SPACE=1, ISSUE=2, RUN=3, PAUSE=4.
- **IDLE:**
  - `s_cmd_ready`=1. It is derived from the state only, not from `s_cmd_valid`.
  - On `s_cmd_valid`, latch all fields and set `rep_left`=`repeat` and `seed_cur`=`seed`.
  - If `length`==0, pulse `err_timeout`=0, increment nothing and stay in IDLE (command discarded). Otherwise go to WAIT_SPACE.
- **WAIT_SPACE:** when `dataq_free` ≥ `length` (11-bit unsigned compare), go to ISSUE.
- **ISSUE:**
  - `m_cmd_valid`=1, with `length`, `mode` and `seed_cur` held stable.
  - On `m_cmd_ready`: load `beats_left`=`length`, clear the watchdog, go to RUN.
- **RUN:**
  - Each `rx_dout_valid` decrements `beats_left` and clears the watchdog.
  - On the beat that takes `beats_left` from 1 to 0: `done`=1 next cycle and `exec_cnt`+1.
  - After that last beat: if `rep_left`>0, decrement `rep_left`, set `seed_cur`=`seed_cur`+1 mod 128, then go to PAUSE (if `pause`>0) or WAIT_SPACE (if `pause`=0). If `rep_left`=0, go to IDLE.
- **PAUSE:** count `pause` cycles exactly, then go to WAIT_SPACE.
- **Watchdog:**
  - Counts RUN cycles without a beat.
  - On reaching `TIMEOUT`: `err_timeout` pulse, `timeout_cnt` saturating +1, go to IDLE, and discard remaining repeats.
- **Abort:**
  - In any state other than IDLE, `abort` forces IDLE on the next cycle. It has priority over every other transition.
  - In ISSUE with `m_cmd_ready`=1 in the same cycle, the command counts as issued but no beats are tracked.
  - `abort` in IDLE has no effect.
- **Stray beats:** `rx_dout_valid` outside RUN, or in the ISSUE→RUN handshake cycle, is ignored.

## Timing
- **Reset values:** state IDLE, `s_cmd_ready`=1, `m_cmd_valid`=0, `m_cmd_*`=0, `done`=0, `err_timeout`=0, `exec_cnt`=0, `timeout_cnt`=0, `busy`=0.
- **Registered outputs:** all outputs except `s_cmd_ready` and `busy` are registered. `s_cmd_ready` and `busy` decode the state register.
- **Accept to issue:** `s_cmd_valid` accepted at cycle N gives `m_cmd_valid` at N+2 at the earliest (WAIT_SPACE is at least 1 cycle).
- **Command handshake:** `m_cmd_valid`, once high, stays high until `m_cmd_ready` or `abort`.
- **Last beat to next issue:** with `pause`=P>0, the last beat at cycle M gives `m_cmd_valid` at M+P+3 at the earliest. With P=0 it is M+2.
- **`done` timing:** `done` asserts the cycle after the last beat.
- **Watchdog timing:** `err_timeout` asserts exactly `TIMEOUT` cycles after the last beat, or after entry into RUN if no beat arrives.

## Structure
- **Package `ofdmbbp_rx_pkg`:** state encoding, `cmd_t` field widths and bit offsets for the 32-bit command word (shared with the AXI-side `cmdq` writer), and the `dataq` depth constant 1024.
- **Sub-module `ofdmbbp_wdog`:** loadable, clearable timeout counter with a single `expired` output, reused by the TX scheduler.

## Test plan
- **Single execution:** cmd length=4, repeat=0, pause=0, `dataq_free`=1024, core ready → one `m_cmd` with seed as given; 4 beats → `done`=1, `exec_cnt`=1, back to IDLE.
- **Repeats with pause:** repeat=2, pause=3, seed=127 → three issues with seeds 127, 0, 1; exactly 3 idle PAUSE cycles between the last beat and WAIT_SPACE; `exec_cnt`=3.
- **Backpressure on `dataq`:** length=200, `dataq_free`=150 held 50 cycles then 200 → `m_cmd_valid` stays low until 2 cycles after `dataq_free`=200; `m_cmd_valid` stays high with fields stable across 5 cycles of `m_cmd_ready`=0.
- **Watchdog:** `TIMEOUT`=16, length=8, core stops after 3 beats → `err_timeout` 16 cycles after beat 3, `timeout_cnt`=1, IDLE, remaining repeats dropped.
- **Abort:** `abort` during RUN and during PAUSE → IDLE next cycle, `m_cmd_valid`=0, no `done`; stray beats afterwards leave `exec_cnt` unchanged.
- **Edges:** length=0 → popped and discarded with no issue. `rst` asserted mid-RUN → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/ofdmbbp_rx_pkg.sv
// ofdmbbp_rx_pkg
// Shared definitions for the OFDM RX command path: scheduler state encoding,
// the 32-bit host command word layout (also used by the AXI-side cmdq
// writer) and the dataq depth.
package ofdmbbp_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SPACE = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_RUN        = 3'd3,
    ST_PAUSE      = 3'd4
  } state_t;

  localparam int PAUSE_W  = 8;
  localparam int REPEAT_W = 7;
  localparam int SEED_W   = 7;
  localparam int MODE_W   = 2;
  localparam int LEN_W    = 8;

  localparam int PAUSE_LSB  = 24;
  localparam int REPEAT_LSB = 17;
  localparam int SEED_LSB   = 10;
  localparam int MODE_LSB   = 8;
  localparam int LEN_LSB    = 0;

  localparam int DATAQ_DEPTH = 1024;
  localparam int FREE_W      = 11;

  // Field order matches the bit offsets above, so a plain cast unpacks a word.
  typedef struct packed {
    logic [PAUSE_W-1:0]  pause;
    logic [REPEAT_W-1:0] rep;
    logic [SEED_W-1:0]   seed;
    logic [MODE_W-1:0]   mode;
    logic [LEN_W-1:0]    length;
  } cmd_t;

  function automatic cmd_t unpack_cmd(input logic [31:0] word);
    return cmd_t'(word);
  endfunction

endpackage

// File: rtl/ofdmbbp_rx_cmd_sched_if.sv
// ofdmbbp_rx_cmd_sched_if
// Command channels around the scheduler.
//   s_cmd_*  : host cmdq side (valid/data in, ready out of the scheduler)
//   m_cmd_*  : RX core command port (valid/payload out, ready in)
// master = scheduler view, slave = host FIFO + RX core view.
interface ofdmbbp_rx_cmd_sched_if;
  import ofdmbbp_rx_pkg::*;

  logic                s_cmd_valid;
  logic                s_cmd_ready;
  logic [31:0]         s_cmd_data;
  logic                m_cmd_valid;
  logic                m_cmd_ready;
  logic [LEN_W-1:0]    m_cmd_length;
  logic [MODE_W-1:0]   m_cmd_mode;
  logic [SEED_W-1:0]   m_cmd_seed;

  modport master (
    input  s_cmd_valid, s_cmd_data, m_cmd_ready,
    output s_cmd_ready, m_cmd_valid, m_cmd_length, m_cmd_mode, m_cmd_seed
  );

  modport slave (
    output s_cmd_valid, s_cmd_data, m_cmd_ready,
    input  s_cmd_ready, m_cmd_valid, m_cmd_length, m_cmd_mode, m_cmd_seed
  );

endinterface

// File: rtl/ofdmbbp_wdog.sv
// ofdmbbp_wdog
// Loadable down-counting timeout counter.
//   clk, rst  : clock, synchronous active-high reset
//   load      : reload counter with load_val (also the "clear" of the watchdog)
//   dec       : count one idle cycle (holds at zero)
//   load_val  : reload value
//   expired   : counter has reached zero
module ofdmbbp_wdog #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ofdmbbp_rx_cmd_sched.sv
// ofdmbbp_rx_cmd_sched
// Expands each host command into repeat+1 RX core executions, gating each on
// dataq space, counting output beats, inserting a pause between executions,
// with watchdog and abort recovery.
//   clk, rst      : sample clock, synchronous active-high reset
//   cmd           : command channels (master modport)
//   rx_dout_valid : RX core output beat
//   dataq_free    : free words in dataq (0..1024)
//   abort         : drop current command, return to IDLE
//   busy, seq_state, done, err_timeout, exec_cnt, timeout_cnt : status
//
// state      | meaning
// IDLE       | cmdq pop enabled, waiting for a command
// WAIT_SPACE | waiting for dataq_free >= length
// ISSUE      | m_cmd_valid high, waiting for core ready
// RUN        | counting output beats, watchdog active
// PAUSE      | gap between executions of a repeated command
module ofdmbbp_rx_cmd_sched
  import ofdmbbp_rx_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  ofdmbbp_rx_cmd_sched_if.master   cmd,
  input  logic                     rx_dout_valid,
  input  logic [FREE_W-1:0]        dataq_free,
  input  logic                     abort,
  output logic                     busy,
  output logic [2:0]               seq_state,
  output logic                     done,
  output logic                     err_timeout,
  output logic [CNT_W-1:0]         exec_cnt,
  output logic [7:0]               timeout_cnt
);

  localparam int WD_W = $clog2(TIMEOUT);
  // Kick loads TIMEOUT-2 so the pulse lands TIMEOUT cycles after the kick
  // cycle: TIMEOUT-2 decrements, one expired cycle, one output register.
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 2);

  state_t              state;
  cmd_t                cmd_in, cmd_q;
  logic [REPEAT_W-1:0] rep_left;
  logic [SEED_W-1:0]   seed_cur;
  logic [LEN_W-1:0]    beats_left;
  logic [PAUSE_W-1:0]  pause_cnt;
  logic                wd_load, wd_dec, wd_expired;

  assign cmd_in          = unpack_cmd(cmd.s_cmd_data);
  assign cmd.s_cmd_ready = (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign seq_state       = state;

  assign wd_load = ((state == ST_ISSUE) && cmd.m_cmd_ready) ||
                   ((state == ST_RUN) && rx_dout_valid);
  assign wd_dec  = (state == ST_RUN) && !rx_dout_valid;

  ofdmbbp_wdog #(.W(WD_W)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .dec      (wd_dec),
    .load_val (WD_LOAD),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      cmd_q            <= '0;
      rep_left         <= '0;
      seed_cur         <= '0;
      beats_left       <= '0;
      pause_cnt        <= '0;
      cmd.m_cmd_valid  <= 1'b0;
      cmd.m_cmd_length <= '0;
      cmd.m_cmd_mode   <= '0;
      cmd.m_cmd_seed   <= '0;
      done             <= 1'b0;
      err_timeout      <= 1'b0;
      exec_cnt         <= '0;
      timeout_cnt      <= '0;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      if ((state != ST_IDLE) && abort) begin
        state           <= ST_IDLE;
        cmd.m_cmd_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd.s_cmd_valid) begin
              cmd_q    <= cmd_in;
              rep_left <= cmd_in.rep;
              seed_cur <= cmd_in.seed;
              // zero-length commands are popped and silently dropped
              if (cmd_in.length != '0) state <= ST_WAIT_SPACE;
            end
          end
          ST_WAIT_SPACE: begin
            if (dataq_free >= {3'b000, cmd_q.length}) begin
              state            <= ST_ISSUE;
              cmd.m_cmd_valid  <= 1'b1;
              cmd.m_cmd_length <= cmd_q.length;
              cmd.m_cmd_mode   <= cmd_q.mode;
              cmd.m_cmd_seed   <= seed_cur;
            end
          end
          ST_ISSUE: begin
            if (cmd.m_cmd_ready) begin
              cmd.m_cmd_valid <= 1'b0;
              beats_left      <= cmd_q.length;
              state           <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (rx_dout_valid) begin
              beats_left <= beats_left - LEN_W'(1);
              if (beats_left == LEN_W'(1)) begin
                done     <= 1'b1;
                exec_cnt <= exec_cnt + CNT_W'(1);
                if (rep_left != '0) begin
                  rep_left  <= rep_left - REPEAT_W'(1);
                  seed_cur  <= seed_cur + SEED_W'(1);
                  pause_cnt <= cmd_q.pause;
                  state     <= (cmd_q.pause != '0) ? ST_PAUSE : ST_WAIT_SPACE;
                end else begin
                  state <= ST_IDLE;
                end
              end
            end else if (wd_expired) begin
              err_timeout <= 1'b1;
              if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
              state <= ST_IDLE;
            end
          end
          ST_PAUSE: begin
            // entry cycle plus `pause` counted cycles: next issue at beat+pause+3
            if (pause_cnt == '0) state <= ST_WAIT_SPACE;
            else pause_cnt <= pause_cnt - PAUSE_W'(1);
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ofdmbbp_rx_cmd_sched.sv
// tb_ofdmbbp_rx_cmd_sched
// Directed bench for the RX command scheduler (TIMEOUT=16). Inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_ofdmbbp_rx_cmd_sched;
  import ofdmbbp_rx_pkg::*;

  logic        clk;
  logic        rst;
  logic        rx_dout_valid;
  logic [10:0] dataq_free;
  logic        abort;
  logic        busy;
  logic [2:0]  seq_state;
  logic        done;
  logic        err_timeout;
  logic [15:0] exec_cnt;
  logic [7:0]  timeout_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ofdmbbp_rx_cmd_sched_if cif ();

  ofdmbbp_rx_cmd_sched #(.TIMEOUT(16), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd           (cif),
    .rx_dout_valid (rx_dout_valid),
    .dataq_free    (dataq_free),
    .abort         (abort),
    .busy          (busy),
    .seq_state     (seq_state),
    .done          (done),
    .err_timeout   (err_timeout),
    .exec_cnt      (exec_cnt),
    .timeout_cnt   (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] p, input logic [6:0] r,
                                     input logic [6:0] s, input logic [1:0] m,
                                     input logic [7:0] l);
    return {p, r, s, m, l};
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; rx_dout_valid = 1'b0; dataq_free = 11'd1024; abort = 1'b0;
    cif.s_cmd_valid = 1'b0; cif.s_cmd_data = '0; cif.m_cmd_ready = 1'b0;
    step(2);
    chk("rst_state",  seq_state, 32'(ST_IDLE));
    chk("rst_sready", cif.s_cmd_ready, 1);
    chk("rst_mvalid", cif.m_cmd_valid, 0);
    chk("rst_mlen",   cif.m_cmd_length, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    chk("rst_err",    err_timeout, 0);
    chk("rst_exec",   exec_cnt, 0);
    chk("rst_tcnt",   timeout_cnt, 0);
    rst = 1'b0;
    step(1);

    // single execution: length 4, seed 0x15, mode 2
    cif.s_cmd_valid = 1'b1; cif.s_cmd_data = mk(8'd0, 7'd0, 7'h15, 2'd2, 8'd4);
    step(1);
    cif.s_cmd_valid = 1'b0;
    chk("s1_wait",   seq_state, 32'(ST_WAIT_SPACE));
    chk("s1_no_early_issue", cif.m_cmd_valid, 0);
    chk("s1_sready_low", cif.s_cmd_ready, 0);
    step(1);
    chk("s1_mvalid", cif.m_cmd_valid, 1);
    chk("s1_len",    cif.m_cmd_length, 4);
    chk("s1_mode",   cif.m_cmd_mode, 2);
    chk("s1_seed",   cif.m_cmd_seed, 32'h15);
    cif.m_cmd_ready = 1'b1;
    step(1);
    cif.m_cmd_ready = 1'b0;
    chk("s1_run",    seq_state, 32'(ST_RUN));
    chk("s1_mvalid_drop", cif.m_cmd_valid, 0);
    rx_dout_valid = 1'b1;
    step(3);
    chk("s1_no_done_3beats", done, 0);
    step(1);
    rx_dout_valid = 1'b0;
    chk("s1_done",   done, 1);
    chk("s1_exec",   exec_cnt, 1);
    chk("s1_idle",   seq_state, 32'(ST_IDLE));
    step(1);
    chk("s1_done_pulse", done, 0);

    // repeat=2, pause=3, seed=127, length 2; a stray beat rides the handshake
    cif.s_cmd_valid = 1'b1; cif.s_cmd_data = mk(8'd3, 7'd2, 7'd127, 2'd1, 8'd2);
    step(1);
    cif.s_cmd_valid = 1'b0;
    step(1);
    for (int e = 0; e < 3; e++) begin
      chk("rep_mvalid", cif.m_cmd_valid, 1);
      chk("rep_seed",   cif.m_cmd_seed, 32'((127 + e) % 128));
      cif.m_cmd_ready = 1'b1; rx_dout_valid = 1'b1;
      step(1);
      cif.m_cmd_ready = 1'b0;
      chk("rep_run", seq_state, 32'(ST_RUN));
      step(1);
      chk("rep_stray_ignored", done, 0);
      step(1);
      rx_dout_valid = 1'b0;
      chk("rep_done", done, 1);
      if (e < 2) begin
        chk("rep_pause_enter", seq_state, 32'(ST_PAUSE));
        step(3);
        chk("rep_pause_hold", seq_state, 32'(ST_PAUSE));
        step(1);
        chk("rep_wait", seq_state, 32'(ST_WAIT_SPACE));
        chk("rep_no_early_issue", cif.m_cmd_valid, 0);
        step(1);
      end else begin
        chk("rep_idle", seq_state, 32'(ST_IDLE));
        chk("rep_exec", exec_cnt, 4);
      end
    end

    // dataq backpressure, core backpressure, abort in RUN, stray beats
    dataq_free = 11'd150;
    cif.s_cmd_valid = 1'b1; cif.s_cmd_data = mk(8'd0, 7'd0, 7'h2A, 2'd3, 8'd200);
    step(1);
    cif.s_cmd_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk("bp_hold_low", cif.m_cmd_valid, 0);
      step(1);
    end
    dataq_free = 11'd200;
    chk("bp_low_at_change", cif.m_cmd_valid, 0);
    step(2);
    for (int i = 0; i < 6; i++) begin
      chk("bp_mvalid", cif.m_cmd_valid, 1);
      chk("bp_len",    cif.m_cmd_length, 200);
      chk("bp_mode",   cif.m_cmd_mode, 3);
      chk("bp_seed",   cif.m_cmd_seed, 32'h2A);
      if (i < 5) step(1);
    end
    dataq_free = 11'd1024;
    cif.m_cmd_ready = 1'b1;
    step(1);
    cif.m_cmd_ready = 1'b0;
    chk("bp_run", seq_state, 32'(ST_RUN));
    rx_dout_valid = 1'b1;
    step(2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_run_idle",   seq_state, 32'(ST_IDLE));
    chk("abort_run_mvalid", cif.m_cmd_valid, 0);
    chk("abort_run_done",   done, 0);
    chk("abort_run_busy",   busy, 0);
    step(3);
    rx_dout_valid = 1'b0;
    chk("stray_done", done, 0);
    chk("stray_exec", exec_cnt, 4);

    // watchdog: length 8, repeat 3, core stalls after 3 beats
    cif.s_cmd_valid = 1'b1; cif.s_cmd_data = mk(8'd0, 7'd3, 7'd5, 2'd0, 8'd8);
    step(1);
    cif.s_cmd_valid = 1'b0;
    step(1);
    chk("wd_issue", cif.m_cmd_valid, 1);
    cif.m_cmd_ready = 1'b1;
    step(1);
    cif.m_cmd_ready = 1'b0;
    rx_dout_valid = 1'b1;
    step(3);
    rx_dout_valid = 1'b0;
    step(14);
    chk("wd_not_yet", err_timeout, 0);
    chk("wd_still_run", seq_state, 32'(ST_RUN));
    step(1);
    chk("wd_err",   err_timeout, 1);
    chk("wd_tcnt",  timeout_cnt, 1);
    chk("wd_idle",  seq_state, 32'(ST_IDLE));
    step(1);
    chk("wd_err_pulse", err_timeout, 0);
    step(3);
    chk("wd_drop_repeats", seq_state, 32'(ST_IDLE));
    chk("wd_no_reissue",   cif.m_cmd_valid, 0);
    chk("wd_exec",         exec_cnt, 4);

    // abort during PAUSE
    cif.s_cmd_valid = 1'b1; cif.s_cmd_data = mk(8'd5, 7'd1, 7'd0, 2'd0, 8'd1);
    step(1);
    cif.s_cmd_valid = 1'b0;
    step(1);
    cif.m_cmd_ready = 1'b1;
    step(1);
    cif.m_cmd_ready = 1'b0;
    rx_dout_valid = 1'b1;
    step(1);
    rx_dout_valid = 1'b0;
    chk("ap_done",  done, 1);
    chk("ap_pause", seq_state, 32'(ST_PAUSE));
    step(1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("ap_idle",   seq_state, 32'(ST_IDLE));
    chk("ap_mvalid", cif.m_cmd_valid, 0);
    chk("ap_done_clr", done, 0);
    step(5);
    chk("ap_no_resume", cif.m_cmd_valid, 0);
    chk("ap_exec", exec_cnt, 5);

    // zero-length command is popped and discarded
    cif.s_cmd_valid = 1'b1; cif.s_cmd_data = mk(8'd0, 7'd0, 7'd3, 2'd1, 8'd0);
    chk("len0_ready", cif.s_cmd_ready, 1);
    step(1);
    cif.s_cmd_valid = 1'b0;
    chk("len0_idle", seq_state, 32'(ST_IDLE));
    chk("len0_err",  err_timeout, 0);
    step(2);
    chk("len0_no_issue", cif.m_cmd_valid, 0);
    chk("len0_exec", exec_cnt, 5);

    // abort in IDLE is ignored; then reset mid-RUN
    abort = 1'b1;
    cif.s_cmd_valid = 1'b1; cif.s_cmd_data = mk(8'd0, 7'd0, 7'd9, 2'd2, 8'd1);
    step(1);
    abort = 1'b0; cif.s_cmd_valid = 1'b0;
    chk("idle_abort_ignored", seq_state, 32'(ST_WAIT_SPACE));
    step(1);
    cif.m_cmd_ready = 1'b1;
    step(1);
    cif.m_cmd_ready = 1'b0;
    chk("rst_mid_run", seq_state, 32'(ST_RUN));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst2_state",  seq_state, 32'(ST_IDLE));
    chk("rst2_mvalid", cif.m_cmd_valid, 0);
    chk("rst2_mlen",   cif.m_cmd_length, 0);
    chk("rst2_mmode",  cif.m_cmd_mode, 0);
    chk("rst2_mseed",  cif.m_cmd_seed, 0);
    chk("rst2_exec",   exec_cnt, 0);
    chk("rst2_tcnt",   timeout_cnt, 0);
    chk("rst2_busy",   busy, 0);
    chk("rst2_done",   done, 0);
    chk("rst2_sready", cif.s_cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
